// File: rtl/divisor_secuencial.sv
// ---------------------------------------------------------------------------
// divisor_secuencial
//
// Multi-cycle unsigned divider using restoring shift-and-subtract. A single
// (WIDTH+1)-bit subtractor is reused over WIDTH iterations; the carry-out of
// each trial subtraction (1 = no borrow) becomes the next quotient bit.
// Operands are exchanged through a start/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      division request, sampled on a rising clk edge (IDLE/FIN only)
//   dividendo  unsigned dividend, captured on an accepted start
//   divisor    unsigned divisor, captured on an accepted start
//   busy       high while iterating
//   done       one-cycle pulse when cociente/residuo become valid
//   cociente   quotient (all ones on divide-by-zero)
//   residuo    remainder (dividend on divide-by-zero)
//   div_cero   divisor was zero for the last accepted operation
//
// Latency: accept edge is edge 0; done rises after edge WIDTH, or after
// edge 0 when the divisor is zero. Results hold until the next completion.
// ---------------------------------------------------------------------------
module divisor_secuencial #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             div_cero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_nx;

  // r: partial remainder, one bit wider than the operands so the trial
  // value T always fits. q: dividend shifting out / quotient shifting in.
  logic [WIDTH:0]   r, r_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic [WIDTH-1:0] dvs, dvs_nx;
  logic [CW-1:0]    cnt, cnt_nx;

  logic             busy_nx, done_nx, div_cero_nx;
  logic [WIDTH-1:0] cociente_nx, residuo_nx;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   d;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH:0]   q_sh;

  // Trial subtraction T - divisor done as T + ~divisor + 1 at WIDTH+1 bits;
  // the extra top bit of the sum is the carry-out, which is 1 exactly when
  // T >= divisor.
  always_comb begin
    t         = {r[WIDTH-1:0], q[WIDTH-1]};
    sum       = {1'b0, t} + {1'b0, ~{1'b0, dvs}} + {{(WIDTH+1){1'b0}}, 1'b1};
    d         = sum[WIDTH:0];
    no_borrow = sum[WIDTH+1];
    q_sh      = {q, no_borrow};
  end

  // Next-state and next-output logic. Every register defaults to holding
  // its value, so results stay stable from done until the next completion.
  always_comb begin
    state_nx    = state;
    r_nx        = r;
    q_nx        = q;
    dvs_nx      = dvs;
    cnt_nx      = cnt;
    busy_nx     = busy;
    done_nx     = done;
    div_cero_nx = div_cero;
    cociente_nx = cociente;
    residuo_nx  = residuo;

    case (state)
      IDLE, FIN: begin
        if (start) begin
          dvs_nx = divisor;
          r_nx   = '0;
          q_nx   = dividendo;
          cnt_nx = CNT_LAST;
          if (divisor == '0) begin
            // Divide-by-zero completes immediately without iterating.
            state_nx    = FIN;
            busy_nx     = 1'b0;
            done_nx     = 1'b1;
            div_cero_nx = 1'b1;
            cociente_nx = '1;
            residuo_nx  = dividendo;
          end else begin
            state_nx    = CALC;
            busy_nx     = 1'b1;
            done_nx     = 1'b0;
            div_cero_nx = 1'b0;
          end
        end else if (state == FIN) begin
          state_nx = IDLE;
          done_nx  = 1'b0;
        end
      end

      CALC: begin
        // Restoring step: keep the difference only when it did not borrow.
        r_nx = no_borrow ? d : t;
        q_nx = q_sh[WIDTH-1:0];
        if (cnt == '0) begin
          // Last iteration publishes the freshly computed values directly.
          cociente_nx = q_sh[WIDTH-1:0];
          residuo_nx  = no_borrow ? d[WIDTH-1:0] : t[WIDTH-1:0];
          busy_nx     = 1'b0;
          done_nx     = 1'b1;
          state_nx    = FIN;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= '0;
      q        <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_cero <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
    end else begin
      state    <= state_nx;
      r        <= r_nx;
      q        <= q_nx;
      dvs      <= dvs_nx;
      cnt      <= cnt_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      div_cero <= div_cero_nx;
      cociente <= cociente_nx;
      residuo  <= residuo_nx;
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// ---------------------------------------------------------------------------
// tb_divisor_secuencial
//
// Self-checking bench for divisor_secuencial (WIDTH = 5): table of directed
// divisions with hand-computed results, hand-written sequences for ignored
// starts, back-to-back accept in FIN and asynchronous reset mid-operation,
// and a sweep of every nonzero-divisor pair against integer / and %.
// ---------------------------------------------------------------------------
module tb_divisor_secuencial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] dividendo;
  logic [4:0] divisor;
  logic       busy;
  logic       done;
  logic [4:0] cociente;
  logic [4:0] residuo;
  logic       div_cero;

  int tests;
  int failures;

  int lat;
  int busy_cycles;
  int overlap;
  int done_count;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] q;
    logic [4:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[12];

  divisor_secuencial #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .cociente  (cociente),
    .residuo   (residuo),
    .div_cero  (div_cero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issues one start, then samples #1 after each edge until done (bounded).
  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    start     = 1'b1;
    dividendo = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start       = 1'b0;
    lat         = 0;
    busy_cycles = busy ? 1 : 0;
    overlap     = (busy && done) ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cycles++;
      if (busy && done) overlap++;
    end
    if (done) done_count++;
  endtask

  initial begin
    int exp_lat;
    int sweep_ops;
    int sweep_bad;
    int done_before;

    tests      = 0;
    failures   = 0;
    done_count = 0;
    start      = 1'b0;
    dividendo  = '0;
    divisor    = '0;

    vecs[0]  = '{5'd23, 5'd4,  5'd5,  5'd3,  1'b0};
    vecs[1]  = '{5'd31, 5'd1,  5'd31, 5'd0,  1'b0};
    vecs[2]  = '{5'd3,  5'd7,  5'd0,  5'd3,  1'b0};
    vecs[3]  = '{5'd31, 5'd31, 5'd1,  5'd0,  1'b0};
    vecs[4]  = '{5'd17, 5'd0,  5'd31, 5'd17, 1'b1};
    vecs[5]  = '{5'd10, 5'd3,  5'd3,  5'd1,  1'b0};
    vecs[6]  = '{5'd9,  5'd2,  5'd4,  5'd1,  1'b0};
    vecs[7]  = '{5'd30, 5'd7,  5'd4,  5'd2,  1'b0};
    vecs[8]  = '{5'd0,  5'd5,  5'd0,  5'd0,  1'b0};
    vecs[9]  = '{5'd16, 5'd3,  5'd5,  5'd1,  1'b0};
    vecs[10] = '{5'd29, 5'd6,  5'd4,  5'd5,  1'b0};
    vecs[11] = '{5'd0,  5'd0,  5'd31, 5'd0,  1'b1};

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset cociente", cociente, 0);
    checkOutput("reset residuo", residuo, 0);
    checkOutput("reset div_cero", div_cero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven divisions
    foreach (vecs[i]) begin
      exp_lat = vecs[i].dz ? 0 : 5;
      applyStimulus(vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d latency", i), lat, exp_lat);
      checkOutput($sformatf("vec%0d busy cycles", i), busy_cycles, exp_lat);
      checkOutput($sformatf("vec%0d busy&done", i), overlap, 0);
      checkOutput($sformatf("vec%0d cociente", i), cociente, vecs[i].q);
      checkOutput($sformatf("vec%0d residuo", i), residuo, vecs[i].r);
      checkOutput($sformatf("vec%0d div_cero", i), div_cero, vecs[i].dz);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d done pulse width", i), done, 0);
      checkOutput($sformatf("vec%0d cociente hold", i), cociente, vecs[i].q);
    end

    // start during CALC is ignored; start in FIN is accepted back-to-back
    @(negedge clk);
    start     = 1'b1;
    dividendo = 5'd23;
    divisor   = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ign busy after accept", busy, 1);
    @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    dividendo = 5'd9;
    divisor   = 5'd2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("ign done", done, 1);
    checkOutput("ign busy", busy, 0);
    checkOutput("ign cociente", cociente, 5);
    checkOutput("ign residuo", residuo, 3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b done cleared", done, 0);
    checkOutput("b2b busy", busy, 1);
    checkOutput("b2b cociente held", cociente, 5);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("b2b latency", lat, 5);
    checkOutput("b2b cociente", cociente, 4);
    checkOutput("b2b residuo", residuo, 1);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    start     = 1'b1;
    dividendo = 5'd30;
    divisor   = 5'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst busy", busy, 0);
    checkOutput("arst done", done, 0);
    checkOutput("arst cociente", cociente, 0);
    checkOutput("arst residuo", residuo, 0);
    checkOutput("arst div_cero", div_cero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5'd30, 5'd7);
    checkOutput("post-rst latency", lat, 5);
    checkOutput("post-rst cociente", cociente, 4);
    checkOutput("post-rst residuo", residuo, 2);

    // Sweep of all nonzero-divisor pairs
    sweep_ops   = 0;
    sweep_bad   = 0;
    done_before = done_count;
    for (int a = 0; a < 32; a++) begin
      for (int b = 1; b < 32; b++) begin
        applyStimulus(5'(a), 5'(b));
        sweep_ops++;
        tests++;
        if (int'(cociente) != a / b || int'(residuo) != a % b ||
            div_cero !== 1'b0 || lat != 5 || overlap != 0) begin
          failures++;
          sweep_bad++;
          $display("[TB] FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d, expected q=%0d r=%0d dz=0 lat=5",
                   a, b, cociente, residuo, div_cero, lat, a / b, a % b);
        end
      end
    end
    checkOutput("sweep done count", done_count - done_before, sweep_ops);
    checkOutput("sweep op count", sweep_ops, 992);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
